nios2_system_ledctl: RTL and testbench

- Parametrised Avalon-MM output PIO for board LEDs, for the Nios II system.
- Adds four things to a plain output PIO:
  - atomic per-bit set and clear registers;
  - a per-channel blink mode driven by a programmable divider;
  - one global PWM brightness duty applied to all lit channels;
  - a registered, glitch-free `out_port`.
- Sits on the system interconnect as a zero-wait-state slave and drives top-level LED pins directly.

---
 rtl/nios2_system_ledctl.sv | 152 +++++++++++++++
 tb/tb_nios2_system_ledctl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_ledctl.sv
// -----------------------------------------------------------------------------
// nios2_system_ledctl
//   Avalon-MM output PIO for board LEDs. On top of a plain output register it
//   provides atomic set/clear, a per-channel blink mode driven by a shared
//   programmable divider, and one global PWM brightness duty applied to all
//   lit channels. The LED pins are driven from a register, so they never glitch.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data (32 bits)
//   readdata    read data, combinational, zero wait states
//   out_port    LED outputs (WIDTH bits), registered
//
// Register map
//   0 DATA  1 MODE  2 BLINK_DIV  3 DUTY  4 OUTSET  5 OUTCLEAR  6 STATUS  7 rsvd
// -----------------------------------------------------------------------------
module nios2_system_ledctl #(
    parameter int          WIDTH       = 5,
    parameter logic [31:0] RESET_VALUE = 32'd31,
    parameter int          DIV_WIDTH   = 24,
    parameter logic [31:0] DEFAULT_DIV = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MODE   = 3'd1;
    localparam logic [2:0] ADDR_DIV    = 3'd2;
    localparam logic [2:0] ADDR_DUTY   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    // Architectural state
    logic [WIDTH-1:0]     data_q,  data_d;
    logic [WIDTH-1:0]     mode_q,  mode_d;
    logic [DIV_WIDTH-1:0] div_q,   div_d;
    logic [7:0]           duty_q,  duty_d;
    // Engine state
    logic [DIV_WIDTH-1:0] bcnt_q,  bcnt_d;
    logic                 phase_q, phase_d;
    logic [7:0]           pcnt_q,  pcnt_d;
    logic [WIDTH-1:0]     out_q,   out_d;

    logic                 wr_s;
    logic                 div_wr_s;
    logic                 pwm_on_s;
    logic [31:0]          rd_s;
    logic                 unused_wd_s;

    assign wr_s     = chipselect & ~write_n;
    assign div_wr_s = wr_s & (address == ADDR_DIV);
    // DUTY = 0xFF is special-cased so full brightness is truly continuous.
    assign pwm_on_s = (duty_q == 8'hFF) | (pcnt_q < duty_q);

    // Write bits above each register's width are dropped; fold them away here.
    assign unused_wd_s = ^writedata;

    // Register-file next state from the bus write
    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        div_d  = div_q;
        duty_d = duty_q;
        if (wr_s) begin
            case (address)
                ADDR_DATA:   data_d = writedata[WIDTH-1:0];
                ADDR_MODE:   mode_d = writedata[WIDTH-1:0];
                ADDR_DIV:    div_d  = writedata[DIV_WIDTH-1:0];
                ADDR_DUTY:   duty_d = writedata[7:0];
                ADDR_OUTSET: data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLR: data_d = data_q & ~writedata[WIDTH-1:0];
                default:     data_d = data_q;   // STATUS and reserved ignore writes
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Blink divider: a BLINK_DIV write restarts the half-period and beats a wrap
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (div_wr_s) begin
            bcnt_d  = {DIV_WIDTH{1'b0}};
            phase_d = 1'b1;
        end else if (bcnt_q == div_q) begin
            bcnt_d  = {DIV_WIDTH{1'b0}};
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + DIV_WIDTH'(1);
            phase_d = phase_q;
        end
    end

    // PWM counter free-runs and wraps naturally; output mask uses current state
    always_comb begin
        pcnt_d = pcnt_q + 8'd1;
        out_d  = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on_s}};
    end

    // Read mux, zero-extended; reflects pre-write values during a write cycle
    always_comb begin
        rd_s = 32'd0;
        case (address)
            ADDR_DATA:   rd_s[WIDTH-1:0]     = data_q;
            ADDR_MODE:   rd_s[WIDTH-1:0]     = mode_q;
            ADDR_DIV:    rd_s[DIV_WIDTH-1:0] = div_q;
            ADDR_DUTY:   rd_s[7:0]           = duty_q;
            ADDR_STATUS: rd_s[1:0]           = {pwm_on_s, phase_q};
            default:     rd_s                = 32'd0;
        endcase
    end

    // All state flops; reset restores every value with nothing left pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE[WIDTH-1:0];
            mode_q  <= {WIDTH{1'b0}};
            div_q   <= DEFAULT_DIV[DIV_WIDTH-1:0];
            duty_q  <= 8'hFF;
            bcnt_q  <= {DIV_WIDTH{1'b0}};
            phase_q <= 1'b1;
            pcnt_q  <= 8'd0;
            out_q   <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q  <= data_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            duty_q  <= duty_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            out_q   <= out_d;
        end
    end

    assign readdata = rd_s;
    assign out_port = out_q;

endmodule

// File: tb/tb_nios2_system_ledctl.sv
// -----------------------------------------------------------------------------
// tb_nios2_system_ledctl
//   Self-checking bench. A behavioural model tracks the register contents and
//   derives the blink phase from the number of clocks since the last restart
//   (reset or BLINK_DIV write) and the PWM count from clocks since reset.
// -----------------------------------------------------------------------------
module tb_nios2_system_ledctl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  out_port;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [4:0]  m_data;
    logic [4:0]  m_mode;
    logic [23:0] m_div;
    logic [7:0]  m_duty;
    longint      m_k;      // clocks since last blink restart
    int          m_pcnt;   // clocks since reset, modulo 256
    logic [4:0]  m_out;

    nios2_system_ledctl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Phase starts high and flips once every (BLINK_DIV+1) clocks
    function automatic logic m_phase();
        return ((m_k / (longint'(m_div) + 64'd1)) % 64'd2) == 64'd0;
    endfunction

    function automatic logic m_pwm();
        return (m_duty == 8'hFF) || (m_pcnt < int'(m_duty));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {27'd0, m_data};
            3'd1:    return {27'd0, m_mode};
            3'd2:    return {8'd0, m_div};
            3'd3:    return {24'd0, m_duty};
            3'd6:    return {30'd0, m_pwm(), m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = 5'h1F;
        m_mode = 5'h00;
        m_div  = 24'd12499999;
        m_duty = 8'hFF;
        m_k    = 0;
        m_pcnt = 0;
        m_out  = 5'h1F;
    endtask

    // One bus cycle: drive after negedge, check read, clock, check LEDs
    task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        logic [4:0] exp_out;
        logic       ph;
        logic       pw;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        #1;
        chk($sformatf("read_a%0d", a), readdata, m_read(a));
        ph = m_phase();
        pw = m_pwm();
        exp_out = m_data & (~m_mode | {5{ph}}) & {5{pw}};
        @(posedge clk);
        m_k = m_k + 1;
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[4:0];
                3'd1: m_mode = wd[4:0];
                3'd2: begin m_div = wd[23:0]; m_k = 0; end
                3'd3: m_duty = wd[7:0];
                3'd4: m_data = m_data | wd[4:0];
                3'd5: m_data = m_data & ~wd[4:0];
                default: ;
            endcase
        end
        m_pcnt = (m_pcnt + 1) % 256;
        m_out  = exp_out;
        @(negedge clk);
        chk("out_port", {27'd0, out_port}, {27'd0, m_out});
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        bus(1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        bus(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b1, 3'(i % 8), 32'hDEAD_BEEF);
    endtask

    initial begin
        int cnt0;
        int cnt4;
        int cnt_any;
        logic [31:0] r;
        logic [2:0]  ra;
        clk        = 1'b0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        n_checks   = 0;
        n_errors   = 0;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", {27'd0, out_port}, 32'h1F);
        reset_n = 1'b1;
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd6); rd(3'd7);

        // DATA write, set, clear
        wr(3'd0, 32'hFFFF_FF0A);
        rd(3'd0);
        chk("data_out", {27'd0, out_port}, 32'h0A);
        wr(3'd4, 32'h11);
        wr(3'd5, 32'h03);
        rd(3'd4);
        rd(3'd5);
        chk("outclr_out", {27'd0, out_port}, 32'h18);

        // Blink on bit 0 with half-period of 4 clocks
        wr(3'd0, 32'h1F);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h3);
        for (int i = 0; i < 24; i++) rd(3'd6);

        // Divider 0 toggles every clock; rewrite on a wrap cycle restarts
        wr(3'd2, 32'h0);
        for (int i = 0; i < 6; i++) rd(3'd6);
        wr(3'd2, 32'h9);
        for (int i = 0; i < 25; i++) rd(3'd6);

        // PWM duty 0x40: 64 of every 256 clocks
        wr(3'd1, 32'h0);
        wr(3'd3, 32'h40);
        idle(2);
        cnt0 = 0; cnt4 = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (out_port[0]) cnt0++;
            if (out_port[4]) cnt4++;
        end
        chk("pwm64_b0", cnt0, 32'd64);
        chk("pwm64_b4", cnt4, 32'd64);

        wr(3'd3, 32'h0);
        idle(2);
        cnt_any = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (out_port != 5'h00) cnt_any++;
        end
        chk("duty0_on", cnt_any, 32'd0);

        wr(3'd3, 32'hFF);
        idle(2);
        cnt_any = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (out_port == 5'h1F) cnt_any++;
        end
        chk("duty255_on", cnt_any, 32'd256);

        // Mid-blink asynchronous reset
        wr(3'd1, 32'h1F);
        wr(3'd3, 32'h10);
        wr(3'd2, 32'h2);
        idle(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {27'd0, out_port}, 32'h1F);
        m_reset();
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            chk($sformatf("rst_read_a%0d", a), readdata, m_read(3'(a)));
        end
        @(negedge clk);
        reset_n = 1'b1;
        wr(3'd7, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd6);

        // Randomized bus traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom;
            ra = 3'($urandom_range(0, 7));
            if (ra == 3'd2) r = (r & 32'hFF00_0000) | 32'($urandom_range(0, 6));
            bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
